// File: rtl/pc_fetch.sv
// pc_fetch: program counter and fetch stage of the picoMIPS core (IDLE/RUN/FLUSH/HALT).
// Optional macro PC_WRAP_TRAP_EN: trap a sequential fetch at the top address instead of wrapping.
`default_nettype none

module pc_fetch #(
    parameter int PSIZE = 6,
    parameter int ISIZE = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [PSIZE-1:0] o_address,
    input  logic [ISIZE-1:0] i_instruction_in,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic             i_branch_abs,
    input  logic [PSIZE-1:0] i_branch_operand,
    output logic [ISIZE-1:0] o_instr_out,
    output logic [PSIZE-1:0] o_instr_pc,
    output logic             o_instr_valid,
    output logic             o_halted,
    output logic             o_wrap_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [PSIZE-1:0] r_address, w_address_nxt;
    logic [PSIZE-1:0] r_instr_pc, w_instr_pc_nxt;
    logic [ISIZE-1:0] r_instr_out, w_instr_out_nxt;
    logic             r_valid, w_valid_nxt;
    logic             w_wrap_set;
    logic             w_accept;
    logic             w_trap;
    logic [PSIZE-1:0] w_target;

    // Same-width add is the sign-extended offset taken mod 2^PSIZE.
    assign w_target = i_branch_abs ? i_branch_operand : (r_instr_pc + i_branch_operand);
    assign w_accept = (r_state == S_RUN) && i_branch_taken && !i_stall && r_valid;

`ifdef PC_WRAP_TRAP_EN
    logic r_wrap_err;
    assign w_trap     = (&r_address) && ((r_state == S_RUN) || (r_state == S_FLUSH));
    assign o_wrap_err = r_wrap_err;
`else
    assign w_trap     = 1'b0;
    assign o_wrap_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_address_nxt   = r_address;
        w_instr_pc_nxt  = r_instr_pc;
        w_instr_out_nxt = r_instr_out;
        w_valid_nxt     = r_valid;
        w_wrap_set      = 1'b0;
        if (r_state == S_HALT) begin
            w_valid_nxt = 1'b0;
        end else if (!i_stall) begin
            if (w_accept) begin
                w_valid_nxt = 1'b0;
                if (w_target == r_instr_pc) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_address_nxt = w_target;
                    w_state_nxt   = S_FLUSH;
                end
            end else if (w_trap) begin
                w_valid_nxt = 1'b0;
                w_wrap_set  = 1'b1;
                w_state_nxt = S_HALT;
            end else begin
                // IDLE, RUN and FLUSH all perform the same sequential fetch here.
                w_instr_out_nxt = i_instruction_in;
                w_instr_pc_nxt  = r_address;
                w_valid_nxt     = 1'b1;
                w_address_nxt   = r_address + 1'b1;
                w_state_nxt     = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_address   <= '0;
            r_instr_pc  <= '0;
            r_instr_out <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_address   <= w_address_nxt;
            r_instr_pc  <= w_instr_pc_nxt;
            r_instr_out <= w_instr_out_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

`ifdef PC_WRAP_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap_err <= 1'b0;
        end else if (w_wrap_set) begin
            r_wrap_err <= 1'b1;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_wrap_set;
`endif

    assign o_address     = r_address;
    assign o_instr_out   = r_instr_out;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_valid;
    assign o_halted      = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed + randomised bench for pc_fetch with a behavioural fetch model.
// Honours PC_WRAP_TRAP_EN the same way as the design.
`default_nettype none

module tb_pc_fetch;

`ifdef PC_WRAP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, bt, babs;
    logic [5:0]  bop;
    logic [5:0]  address;
    logic [23:0] instr_in, instr_out;
    logic [5:0]  instr_pc;
    logic        instr_valid, halted, wrap_err;
    logic [23:0] rom [0:63];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          run_chk = 1'b0;

    always #5 clk = ~clk;

    assign instr_in = rom[address];

    pc_fetch #(.PSIZE(6), .ISIZE(24)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_address        (address),
        .i_instruction_in (instr_in),
        .i_stall          (stall),
        .i_branch_taken   (bt),
        .i_branch_abs     (babs),
        .i_branch_operand (bop),
        .o_instr_out      (instr_out),
        .o_instr_pc       (instr_pc),
        .o_instr_valid    (instr_valid),
        .o_halted         (halted),
        .o_wrap_err       (wrap_err)
    );

    // Behavioural model: PC, last delivered word, and sticky halt/wrap flags.
    logic [5:0]  m_pc, m_ipc;
    logic [23:0] m_iout;
    logic        m_valid, m_halt, m_wrap;

    function automatic logic [5:0] target_of(input logic a, input logic [5:0] op,
                                             input logic [5:0] ipc);
        int off, t;
        if (a) return op;
        off = op[5] ? int'(op) - 64 : int'(op);
        t = ((int'(ipc) + off) % 64 + 64) % 64;
        return 6'(t);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= '0; m_ipc <= '0; m_iout <= '0;
            m_valid <= 1'b0; m_halt <= 1'b0; m_wrap <= 1'b0;
        end else if (!m_halt && !stall) begin
            if (m_valid && bt) begin
                m_valid <= 1'b0;
                if (target_of(babs, bop, m_ipc) == m_ipc) m_halt <= 1'b1;
                else m_pc <= target_of(babs, bop, m_ipc);
            end else if (TRAP && m_pc == 6'd63) begin
                m_valid <= 1'b0; m_halt <= 1'b1; m_wrap <= 1'b1;
            end else begin
                m_iout <= rom[m_pc]; m_ipc <= m_pc; m_valid <= 1'b1;
                m_pc <= m_pc + 6'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            chk("model address",   32'(address),     32'(m_pc));
            chk("model instr_out", 32'(instr_out),   32'(m_iout));
            chk("model instr_pc",  32'(instr_pc),    32'(m_ipc));
            chk("model valid",     32'(instr_valid), 32'(m_valid));
            chk("model halted",    32'(halted),      32'(m_halt));
            chk("model wrap_err",  32'(wrap_err),    32'(m_wrap));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; bt = 1'b0; babs = 1'b0; bop = '0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic branch(input logic a, input logic [5:0] op);
        bt = 1'b1; babs = a; bop = op;
        step(1);
        bt = 1'b0; babs = 1'b0; bop = '0;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) rom[k] = 24'(k);
        rst_n = 1'b0; stall = 1'b0; bt = 1'b0; babs = 1'b0; bop = '0;
        step(1);
        run_chk = 1'b1;

        // Reset state and plain sequential run
        do_reset();
        chk("reset address", 32'(address), 0);
        chk("reset valid",   32'(instr_valid), 0);
        chk("reset halted",  32'(halted), 0);
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("run instr_out", 32'(instr_out), 32'(k));
            chk("run instr_pc",  32'(instr_pc), 32'(k));
            chk("run valid",     32'(instr_valid), 1);
        end
        chk("run address", 32'(address), 5);

        // Stall for 3 cycles at instr_pc 2 with an ignored branch pulse
        do_reset();
        step(3);
        stall = 1'b1; bt = 1'b1; babs = 1'b1; bop = 6'd30;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("stall instr_pc", 32'(instr_pc), 2);
            chk("stall address",  32'(address), 3);
            chk("stall valid",    32'(instr_valid), 1);
        end
        stall = 1'b0; bt = 1'b0; bop = '0; babs = 1'b0;
        step(1);
        chk("stall resume", 32'(instr_pc), 3);

        // Absolute branch from 4 to 20
        do_reset();
        step(5);
        chk("abs pre pc", 32'(instr_pc), 4);
        branch(1'b1, 6'd20);
        chk("abs bubble valid", 32'(instr_valid), 0);
        chk("abs bubble addr",  32'(address), 20);
        step(1);
        chk("abs instr_out", 32'(instr_out), 20);
        chk("abs instr_pc",  32'(instr_pc), 20);
        chk("abs valid",     32'(instr_valid), 1);

        // Relative branch -3 from 10
        do_reset();
        step(11);
        branch(1'b0, 6'b111101);
        chk("rel bubble addr", 32'(address), 7);
        chk("rel bubble valid", 32'(instr_valid), 0);
        step(1);
        chk("rel instr_pc", 32'(instr_pc), 7);

        // Relative branch -5 from 2 wraps to 61
        do_reset();
        step(3);
        branch(1'b0, 6'b111011);
        chk("relwrap addr", 32'(address), 61);
        step(1);
        chk("relwrap instr_pc", 32'(instr_pc), 61);

        // Self-loop at 12 parks the stage, then asynchronous reset
        do_reset();
        step(13);
        branch(1'b1, 6'd12);
        chk("halt halted", 32'(halted), 1);
        chk("halt valid",  32'(instr_valid), 0);
        chk("halt addr",   32'(address), 13);
        step(3);
        chk("halt frozen addr", 32'(address), 13);
        chk("halt still",       32'(halted), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async addr",      32'(address), 0);
        chk("async instr_out", 32'(instr_out), 0);
        chk("async instr_pc",  32'(instr_pc), 0);
        chk("async halted",    32'(halted), 0);
        chk("async valid",     32'(instr_valid), 0);
        chk("async wrap_err",  32'(wrap_err), 0);

        // Sequential run across the top of the address space
        do_reset();
        step(1);
        branch(1'b1, 6'd60);
        step(1);
        chk("wrap start", 32'(instr_pc), 60);
        step(2);
        chk("wrap 62", 32'(instr_pc), 62);
        step(1);
        if (TRAP) begin
            chk("trap last pc", 32'(instr_pc), 62);
            chk("trap halted",  32'(halted), 1);
            chk("trap wrap_err", 32'(wrap_err), 1);
            chk("trap valid",   32'(instr_valid), 0);
            step(2);
            chk("trap hold pc", 32'(instr_pc), 62);
        end else begin
            chk("wrap 63", 32'(instr_pc), 63);
            step(1);
            chk("wrap 0", 32'(instr_pc), 0);
            chk("wrap valid", 32'(instr_valid), 1);
            chk("wrap_err low", 32'(wrap_err), 0);
        end

        // Randomised stall/branch traffic against the model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int c = 0; c < 120; c++) begin
                stall = ($urandom_range(0, 3) == 0);
                bt    = ($urandom_range(0, 4) == 0);
                babs  = 1'($urandom_range(0, 1));
                bop   = 6'($urandom_range(0, 63));
                step(1);
            end
        end

        stall = 1'b0; bt = 1'b0;
        step(1);
        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and fetch stage of the picoMIPS core: drives the address of the combinational program memory and registers the returned 24-bit instruction for the decoder. It handles sequential increment, stall, and absolute and relative branches with a one-cycle flush bubble. A taken branch to itself parks the core in a halt state.

## Interface
- Psize, 6: program address width; matches program memory `p`
- Isize, 24: instruction width; matches program memory `i`

- clk  in  1  system clock, rising edge
- nReset  in  1  asynchronous, active-low reset
- address  out  Psize  current PC; drives program memory address
- instruction_in  in  Isize  combinational program memory output for `address`
- stall  in  1  hold the whole stage
- branch_taken  in  1  decoder: the presented instruction branches
- branch_abs  in  1  1 = absolute target; 0 = PC-relative
- branch_operand  in  Psize  absolute target, or signed two's-complement offset
- instr_out  out  Isize  registered instruction to the decoder
- instr_pc  out  Psize  address of `instr_out`
- instr_valid  out  1  `instr_out` is a valid, on-path instruction
- halted  out  1  stage parked in HALT
- wrap_err  out  1  sequential PC overflow trapped (see Configuration)

## Operation
- States: IDLE, RUN, FLUSH, HALT.
- Reset values:
  - address = 0, instr_out = 0, instr_pc = 0.
  - instr_valid = 0, halted = 0, wrap_err = 0.
  - State = IDLE.
- IDLE: first edge after reset release captures instruction_in at PC 0 (instr_pc = 0, valid = 1), sets PC = 1, and moves to RUN. `stall` high keeps the stage in IDLE.
- RUN, stall = 0, branch not accepted:
  - instr_out <= instruction_in, instr_pc <= address, instr_valid <= 1.
  - address <= address + 1, mod 2^Psize.
- Branch accepted only when branch_taken = 1, stall = 0, instr_valid = 1 and state is RUN.
- Branch target:
  - branch_abs = 1: target = branch_operand.
  - branch_abs = 0: target = instr_pc + sign-extended branch_operand, mod 2^Psize.
- Accepted branch with target ≠ instr_pc:
  - address <= target, instr_valid <= 0 (wrong-path fetch discarded), state -> FLUSH.
- FLUSH: behaves like RUN for one sequential fetch (captures I(target), valid = 1, PC = target + 1), then -> RUN. branch_taken is ignored in FLUSH because instr_valid = 0.
- Accepted branch with target = instr_pc (self-loop): state -> HALT.
- HALT:
  - instr_valid = 0, halted = 1.
  - address, instr_out and instr_pc hold.
  - Exit only through reset.
- stall = 1 in any state except HALT: every register and the state hold; branch_taken is ignored.
- Reset mid-operation: all outputs return to their reset values asynchronously, regardless of state.

## Timing
- Latency: address -> instr_out is 1 cycle (sampled at the edge that ends the cycle in which address is presented).
- Throughput: 1 instruction/cycle when not stalled.
- Taken branch costs exactly 1 bubble cycle (instr_valid low for one cycle).
- branch_taken, branch_abs and branch_operand are sampled at the same edge as the transition they cause; they must be stable before that edge.
- halted rises in the cycle after the accepting edge.
- Deassertion of nReset must be synchronous to clk (handled upstream).

## Configuration
- Macro: PC_WRAP_TRAP_EN.
- Defined:
  - Trigger: in RUN or FLUSH, an unstalled fetch at address = 2^Psize−1 does not capture that word.
  - Response: state -> HALT, halted = 1, wrap_err = 1.
  - The last executable address is therefore 2^Psize−2.
- Undefined: PC wraps from 2^Psize−1 to 0 silently; wrap_err is tied 0.

## Test plan
- Reset and run: release nReset, load ROM word k = k, stall = 0 for 5 cycles.
  - Required: instr_out = 0,1,2,3,4; instr_pc matches; instr_valid = 1 from the first edge; address = 5 after 5 edges.
- Stall: assert stall for 3 cycles while instr_pc = 2.
  - Required: address, instr_out and instr_valid hold for 3 cycles; a branch_taken pulse during the stall has no effect; sequence resumes with 3.
- Absolute branch: at instr_pc = 4, branch_taken = 1, branch_abs = 1, operand = 20.
  - Required: next cycle instr_valid = 0, address = 20; following cycle instr_out = I(20), instr_pc = 20, valid = 1.
- Relative branch, negative: at instr_pc = 10, branch_abs = 0, operand = 6'b111101 (−3).
  - Required: target 7, one bubble, then instr_pc = 7.
- Relative branch, wrap: at instr_pc = 2, operand = −5.
  - Required: target 61.
- Self-loop: at instr_pc = 12, branch_abs = 1, operand = 12.
  - Required: halted = 1 the next cycle, instr_valid stays 0, address frozen.
  - Then assert nReset low mid-HALT: all outputs return to 0.
- Wrap behaviour: run sequentially from 60.
  - Without PC_WRAP_TRAP_EN: instr_pc = 60,61,62,63,0, and wrap_err stays 0.
  - With PC_WRAP_TRAP_EN: last valid instr_pc = 62, then halted = 1, wrap_err = 1, and I(63) is never delivered.
